// File: rtl/ramp_pkg.sv
// Shared types and default constants for the ramp source controller.
package ramp_pkg;

    localparam int unsigned DEF_NSRC        = 2;
    localparam int unsigned DEF_DAC_W       = 8;
    localparam int unsigned DEF_SETTLE      = 4;
    localparam int unsigned DEF_SYNC_STAGES = 2;

    // Wide enough for the largest legal SETTLE value (255).
    localparam int unsigned CNT_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_BLANK  = 2'd1,
        ST_ACTIVE = 2'd2
    } state_e;

endpackage

// File: rtl/comp_sync.sv
// Multi-flop synchroniser for one asynchronous comparator input.
// Also exposes the value about to enter the last stage, so a downstream flop can mirror it.
module comp_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic async_i,
    output logic sync_o,
    output logic sync_nxt_o
);

    logic [SYNC_STAGES-1:0] ff_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ff_q <= '0;
        end else begin
            ff_q <= {ff_q[SYNC_STAGES-2:0], async_i};
        end
    end

    assign sync_o     = ff_q[SYNC_STAGES-1];
    assign sync_nxt_o = ff_q[SYNC_STAGES-2];

endmodule

// File: rtl/ramp_src_ctrl.sv
// Ramp source selector: break-before-make switching between NSRC ramp sources,
// with per-source comparator synchronisation and rising-crossing detection.
module ramp_src_ctrl
    import ramp_pkg::*;
#(
    parameter int unsigned NSRC        = DEF_NSRC,
    parameter int unsigned DAC_W       = DEF_DAC_W,
    parameter int unsigned SETTLE      = DEF_SETTLE,
    parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int unsigned SEL_W       = $clog2(NSRC + 1)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    sel_valid,
    output logic                    sel_ready,
    input  logic [SEL_W-1:0]        sel_src,
    input  logic [NSRC*DAC_W-1:0]   src_code_in,
    input  logic [NSRC-1:0]         comp_in,
    output logic [NSRC*DAC_W-1:0]   src_code_out,
    output logic [SEL_W-1:0]        active_src,
    output logic                    comp_out,
    output logic                    comp_valid,
    output logic                    cross_pulse
);

    localparam int unsigned      CODE_W   = NSRC * DAC_W;
    localparam logic [SEL_W-1:0] SRC_NONE = SEL_W'(NSRC);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE - 1);

    state_e              state_q, state_d;
    logic [SEL_W-1:0]    active_src_q, active_src_d;
    logic [CNT_W-1:0]    blank_cnt_q, blank_cnt_d;
    logic [CODE_W-1:0]   code_q, code_d;
    logic                comp_out_q, comp_out_d;
    logic                comp_valid_q, comp_valid_d;
    logic                cross_q, cross_d;
    logic                accept;
    logic                prev_comp;
    logic [NSRC-1:0]     sync_s;
    logic [NSRC-1:0]     sync_nxt_s;

    for (genvar g = 0; g < NSRC; g++) begin : g_sync
        comp_sync #(
            .SYNC_STAGES(SYNC_STAGES)
        ) u_comp_sync (
            .clk       (clk),
            .rst_n     (rst_n),
            .async_i   (comp_in[g]),
            .sync_o    (sync_s[g]),
            .sync_nxt_o(sync_nxt_s[g])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            active_src_q <= SRC_NONE;
            blank_cnt_q  <= '0;
            code_q       <= '0;
            comp_out_q   <= 1'b0;
            comp_valid_q <= 1'b0;
            cross_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            active_src_q <= active_src_d;
            blank_cnt_q  <= blank_cnt_d;
            code_q       <= code_d;
            comp_out_q   <= comp_out_d;
            comp_valid_q <= comp_valid_d;
            cross_q      <= cross_d;
        end
    end

    // Next state plus next output values; outputs are derived from state_d so that
    // the registered outputs line up with the state they belong to.
    always_comb begin
        state_d      = state_q;
        active_src_d = active_src_q;
        blank_cnt_d  = blank_cnt_q;
        code_d       = '0;
        comp_out_d   = 1'b0;
        prev_comp    = 1'b0;
        sel_ready    = (state_q != ST_BLANK);
        accept       = sel_valid && sel_ready;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (sel_src < SRC_NONE) begin
                        active_src_d = sel_src;
                        blank_cnt_d  = CNT_LOAD;
                        state_d      = ST_BLANK;
                    end else begin
                        active_src_d = SRC_NONE;
                    end
                end
            end
            ST_BLANK: begin
                if (blank_cnt_q == '0) begin
                    state_d = ST_ACTIVE;
                end else begin
                    blank_cnt_d = blank_cnt_q - CNT_W'(1);
                end
            end
            ST_ACTIVE: begin
                if (accept) begin
                    if (sel_src >= SRC_NONE) begin
                        active_src_d = SRC_NONE;
                        state_d      = ST_IDLE;
                    end else if (sel_src != active_src_q) begin
                        active_src_d = sel_src;
                        blank_cnt_d  = CNT_LOAD;
                        state_d      = ST_BLANK;
                    end
                end
            end
            default: begin
                active_src_d = SRC_NONE;
                blank_cnt_d  = '0;
                state_d      = ST_IDLE;
            end
        endcase

        for (int unsigned k = 0; k < NSRC; k++) begin
            if ((state_d == ST_ACTIVE) && (active_src_d == SEL_W'(k))) begin
                code_d[k*DAC_W +: DAC_W] = src_code_in[k*DAC_W +: DAC_W];
                comp_out_d               = sync_nxt_s[k];
                prev_comp                = sync_s[k];
            end
        end

        comp_valid_d = (state_d == ST_ACTIVE);
        // Crossing only counts between two ACTIVE cycles on the same source.
        cross_d = (state_d == ST_ACTIVE) && (state_q == ST_ACTIVE) && comp_out_d && !prev_comp;
    end

    assign src_code_out = code_q;
    assign active_src   = active_src_q;
    assign comp_out     = comp_out_q;
    assign comp_valid   = comp_valid_q;
    assign cross_pulse  = cross_q;

endmodule

// File: tb/tb_ramp_src_ctrl.sv
// Self-checking bench for ramp_src_ctrl (NSRC=2, DAC_W=8, SETTLE=4, SYNC_STAGES=2).
module tb_ramp_src_ctrl;

    localparam int unsigned NSRC        = 2;
    localparam int unsigned DAC_W       = 8;
    localparam int unsigned SETTLE      = 4;
    localparam int unsigned SYNC_STAGES = 2;
    localparam int unsigned SEL_W       = 2;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic                  sel_valid;
    logic                  sel_ready;
    logic [SEL_W-1:0]      sel_src;
    logic [NSRC*DAC_W-1:0] src_code_in;
    logic [NSRC-1:0]       comp_in;
    logic [NSRC*DAC_W-1:0] src_code_out;
    logic [SEL_W-1:0]      active_src;
    logic                  comp_out;
    logic                  comp_valid;
    logic                  cross_pulse;

    int n_cmp = 0;
    int n_err = 0;

    // Expected src_code_out values, pushed when the code is driven.
    logic [15:0] exp_code_q[$];
    logic [15:0] e;

    // {sel_ready, active_src, src_code_out, comp_out, comp_valid, cross_pulse}
    logic [21:0] obs;
    assign obs = {sel_ready, active_src, src_code_out, comp_out, comp_valid, cross_pulse};

    ramp_src_ctrl #(
        .NSRC       (NSRC),
        .DAC_W      (DAC_W),
        .SETTLE     (SETTLE),
        .SYNC_STAGES(SYNC_STAGES),
        .SEL_W      (SEL_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .sel_valid   (sel_valid),
        .sel_ready   (sel_ready),
        .sel_src     (sel_src),
        .src_code_in (src_code_in),
        .comp_in     (comp_in),
        .src_code_out(src_code_out),
        .active_src  (active_src),
        .comp_out    (comp_out),
        .comp_valid  (comp_valid),
        .cross_pulse (cross_pulse)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n       = 1'b0;
        sel_valid   = 1'b0;
        sel_src     = 2'd0;
        src_code_in = 16'h5A5A;
        comp_in     = 2'b11;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if (obs !== {1'b1, 2'd2, 16'h0000, 3'b000}) begin
            n_err++;
            $display("FAIL reset_hold: got %h want %h", obs, {1'b1, 2'd2, 16'h0000, 3'b000});
        end
        #2 rst_n = 1'b1;
        comp_in = 2'b00;
        repeat (3) tick();
        n_cmp++;
        if (obs !== {1'b1, 2'd2, 16'h0000, 3'b000}) begin
            n_err++;
            $display("FAIL reset_release_idle: got %h want %h", obs, {1'b1, 2'd2, 16'h0000, 3'b000});
        end
    endtask

    task automatic test_select_r2r();
        logic [15:0] c;
        sel_valid = 1'b1;
        sel_src   = 2'd1;
        tick();
        sel_valid = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            n_cmp++;
            if (obs !== {1'b0, 2'd1, 16'h0000, 3'b000}) begin
                n_err++;
                $display("FAIL r2r_blank_%0d: got %h want %h", i, obs, {1'b0, 2'd1, 16'h0000, 3'b000});
            end
            if (i == 4) begin
                src_code_in = 16'hA501;
                exp_code_q.push_back(16'hA500);
            end else begin
                src_code_in = 16'($urandom);
            end
            tick();
        end
        e = exp_code_q.pop_front();
        n_cmp++;
        if (obs !== {1'b1, 2'd1, e, 3'b010}) begin
            n_err++;
            $display("FAIL r2r_first_active: got %h want %h", obs, {1'b1, 2'd1, e, 3'b010});
        end
        for (int n = 0; n < 6; n++) begin
            c = 16'($urandom);
            src_code_in = c;
            exp_code_q.push_back({c[15:8], 8'h00});
            tick();
            e = exp_code_q.pop_front();
            n_cmp++;
            if (obs !== {1'b1, 2'd1, e, 3'b010}) begin
                n_err++;
                $display("FAIL r2r_track_%0d: got %h want %h", n, obs, {1'b1, 2'd1, e, 3'b010});
            end
        end
    endtask

    task automatic test_switch_pwm();
        logic b;
        sel_valid   = 1'b1;
        sel_src     = 2'd0;
        src_code_in = 16'h3C01;
        tick();
        sel_valid = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            n_cmp++;
            if (obs !== {1'b0, 2'd0, 16'h0000, 3'b000}) begin
                n_err++;
                $display("FAIL pwm_blank_%0d: got %h want %h", i, obs, {1'b0, 2'd0, 16'h0000, 3'b000});
            end
            b = 1'($urandom);
            src_code_in = {8'($urandom), 7'd0, b};
            if (i == 4) exp_code_q.push_back({8'h00, 7'd0, b});
            tick();
        end
        for (int n = 0; n < 7; n++) begin
            e = exp_code_q.pop_front();
            n_cmp++;
            if (obs !== {1'b1, 2'd0, e, 3'b010}) begin
                n_err++;
                $display("FAIL pwm_track_%0d: got %h want %h", n, obs, {1'b1, 2'd0, e, 3'b010});
            end
            b = (n % 2 == 0) ? 1'b1 : 1'b0;
            src_code_in = {8'($urandom), 7'd0, b};
            exp_code_q.push_back({8'h00, 7'd0, b});
            tick();
        end
        exp_code_q.delete();
    endtask

    task automatic test_comp_cross();
        src_code_in = 16'hFF01;
        tick();
        comp_in = 2'b01;
        n_cmp++;
        if (obs !== {1'b1, 2'd0, 16'h0001, 3'b010}) begin
            n_err++;
            $display("FAIL cross_c0: got %h want %h", obs, {1'b1, 2'd0, 16'h0001, 3'b010});
        end
        tick();
        n_cmp++;
        if (obs !== {1'b1, 2'd0, 16'h0001, 3'b010}) begin
            n_err++;
            $display("FAIL cross_c1: got %h want %h", obs, {1'b1, 2'd0, 16'h0001, 3'b010});
        end
        tick();
        n_cmp++;
        if (obs !== {1'b1, 2'd0, 16'h0001, 3'b111}) begin
            n_err++;
            $display("FAIL cross_c2: got %h want %h", obs, {1'b1, 2'd0, 16'h0001, 3'b111});
        end
        for (int n = 0; n < 6; n++) begin
            tick();
            n_cmp++;
            if (obs !== {1'b1, 2'd0, 16'h0001, 3'b110}) begin
                n_err++;
                $display("FAIL cross_hold_%0d: got %h want %h", n, obs, {1'b1, 2'd0, 16'h0001, 3'b110});
            end
            comp_in[1] = ~comp_in[1];
        end
        comp_in = 2'b00;
        tick();
        tick();
        for (int n = 0; n < 5; n++) begin
            n_cmp++;
            if (obs !== {1'b1, 2'd0, 16'h0001, 3'b010}) begin
                n_err++;
                $display("FAIL cross_fall_%0d: got %h want %h", n, obs, {1'b1, 2'd0, 16'h0001, 3'b010});
            end
            comp_in[1] = ~comp_in[1];
            tick();
        end
        comp_in = 2'b00;
    endtask

    task automatic test_same_src();
        comp_in = 2'b01;
        repeat (3) tick();
        n_cmp++;
        if (obs !== {1'b1, 2'd0, 16'h0001, 3'b110}) begin
            n_err++;
            $display("FAIL same_pre: got %h want %h", obs, {1'b1, 2'd0, 16'h0001, 3'b110});
        end
        sel_valid = 1'b1;
        sel_src   = 2'd0;
        tick();
        sel_valid = 1'b0;
        for (int n = 0; n < 4; n++) begin
            n_cmp++;
            if (obs !== {1'b1, 2'd0, 16'h0001, 3'b110}) begin
                n_err++;
                $display("FAIL same_src_%0d: got %h want %h", n, obs, {1'b1, 2'd0, 16'h0001, 3'b110});
            end
            tick();
        end
        sel_valid = 1'b1;
        sel_src   = 2'd2;
        tick();
        sel_valid = 1'b0;
        for (int n = 0; n < 2; n++) begin
            n_cmp++;
            if (obs !== {1'b1, 2'd2, 16'h0000, 3'b000}) begin
                n_err++;
                $display("FAIL disable_%0d: got %h want %h", n, obs, {1'b1, 2'd2, 16'h0000, 3'b000});
            end
            tick();
        end
        comp_in = 2'b00;
        repeat (3) tick();
    endtask

    task automatic test_back_to_back();
        sel_valid = 1'b1;
        sel_src   = 2'd1;
        tick();
        sel_src = 2'd0;
        for (int i = 1; i <= 4; i++) begin
            n_cmp++;
            if (obs !== {1'b0, 2'd1, 16'h0000, 3'b000}) begin
                n_err++;
                $display("FAIL b2b_blank1_%0d: got %h want %h", i, obs, {1'b0, 2'd1, 16'h0000, 3'b000});
            end
            if (i == 4) begin
                src_code_in = 16'h7E00;
                exp_code_q.push_back(16'h7E00);
            end
            tick();
        end
        e = exp_code_q.pop_front();
        n_cmp++;
        if (obs !== {1'b1, 2'd1, e, 3'b010}) begin
            n_err++;
            $display("FAIL b2b_active1: got %h want %h", obs, {1'b1, 2'd1, e, 3'b010});
        end
        tick();
        sel_valid = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            n_cmp++;
            if (obs !== {1'b0, 2'd0, 16'h0000, 3'b000}) begin
                n_err++;
                $display("FAIL b2b_blank0_%0d: got %h want %h", i, obs, {1'b0, 2'd0, 16'h0000, 3'b000});
            end
            if (i == 4) begin
                src_code_in = 16'h1201;
                exp_code_q.push_back(16'h0001);
            end
            tick();
        end
        e = exp_code_q.pop_front();
        n_cmp++;
        if (obs !== {1'b1, 2'd0, e, 3'b010}) begin
            n_err++;
            $display("FAIL b2b_active0: got %h want %h", obs, {1'b1, 2'd0, e, 3'b010});
        end
    endtask

    task automatic test_reset_mid();
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if (obs !== {1'b1, 2'd2, 16'h0000, 3'b000}) begin
            n_err++;
            $display("FAIL rst_mid_active: got %h want %h", obs, {1'b1, 2'd2, 16'h0000, 3'b000});
        end
        #1 rst_n = 1'b1;
        tick();
        sel_valid = 1'b1;
        sel_src   = 2'd1;
        tick();
        sel_valid = 1'b0;
        tick();
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if (obs !== {1'b1, 2'd2, 16'h0000, 3'b000}) begin
            n_err++;
            $display("FAIL rst_mid_blank: got %h want %h", obs, {1'b1, 2'd2, 16'h0000, 3'b000});
        end
        tick();
        n_cmp++;
        if (obs !== {1'b1, 2'd2, 16'h0000, 3'b000}) begin
            n_err++;
            $display("FAIL rst_held: got %h want %h", obs, {1'b1, 2'd2, 16'h0000, 3'b000});
        end
        #1 rst_n = 1'b1;
        sel_valid = 1'b1;
        sel_src   = 2'd1;
        tick();
        sel_valid = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            n_cmp++;
            if (obs !== {1'b0, 2'd1, 16'h0000, 3'b000}) begin
                n_err++;
                $display("FAIL rst_reblank_%0d: got %h want %h", i, obs, {1'b0, 2'd1, 16'h0000, 3'b000});
            end
            if (i == 4) begin
                src_code_in = 16'hC300;
                exp_code_q.push_back(16'hC300);
            end
            tick();
        end
        e = exp_code_q.pop_front();
        n_cmp++;
        if (obs !== {1'b1, 2'd1, e, 3'b010}) begin
            n_err++;
            $display("FAIL rst_reactive: got %h want %h", obs, {1'b1, 2'd1, e, 3'b010});
        end
    endtask

    initial begin
        test_reset();
        test_select_r2r();
        test_switch_pwm();
        test_comp_cross();
        test_same_src();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
